// File: rtl/lemming_level_ctrl.sv
// Level controller for a single lemming walker:
// spawns, tracks falls, counts saved and lost lemmings.
module lemming_level_ctrl #(
  parameter int NUM_LEMMINGS = 10,
  parameter int SPAWN_GAP    = 4,
  parameter int FALL_LIMIT   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       walk_left,
  input  logic       walk_right,
  input  logic       aaah,
  input  logic       at_exit,
  input  logic       dig_req,
  output logic       lem_reset,
  output logic       dig,
  output logic       splat,
  output logic       saved,
  output logic [3:0] saved_cnt,
  output logic [3:0] lost_cnt,
  output logic [3:0] remaining,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    SPAWN,
    ACTIVE,
    DONE
  } state_t;

  localparam logic [3:0] NUM_L = 4'(NUM_LEMMINGS);
  localparam logic [3:0] GAP_L = 4'(SPAWN_GAP);
  localparam logic [4:0] LIM_L = 5'(FALL_LIMIT);
  localparam logic [4:0] SAT_L = 5'd31;

  state_t     state;
  state_t     state_n;
  logic [3:0] timer;
  logic [3:0] timer_n;
  logic [4:0] fall_cnt;
  logic [4:0] fall_n;
  logic       prev_aaah;
  logic       prev_aaah_n;
  logic       prev_dig;

  logic       lem_reset_n;
  logic       dig_n;
  logic       splat_n;
  logic       saved_n;
  logic [3:0] saved_cnt_n;
  logic [3:0] lost_cnt_n;
  logic [3:0] remaining_n;
  logic       done_n;

  logic       walking;
  logic       landed;
  logic       hit_floor;
  logic       at_home;
  logic       dig_edge;
  logic       retire;

  assign walking   = walk_left | walk_right;
  assign landed    = prev_aaah & ~aaah;
  assign hit_floor = landed && (fall_cnt > LIM_L);
  assign at_home   = at_exit & walking & ~aaah;
  assign dig_edge  = dig_req & ~prev_dig;

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    fall_n      = fall_cnt;
    prev_aaah_n = 1'b0;
    dig_n       = 1'b0;
    splat_n     = 1'b0;
    saved_n     = 1'b0;
    saved_cnt_n = saved_cnt;
    lost_cnt_n  = lost_cnt;
    remaining_n = remaining;
    retire      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n     = SPAWN;
          timer_n     = GAP_L;
          saved_cnt_n = 4'd0;
          lost_cnt_n  = 4'd0;
          remaining_n = NUM_L;
        end
      end
      SPAWN: begin
        timer_n = timer - 4'd1;
        if (timer == 4'd1) begin
          state_n     = ACTIVE;
          remaining_n = remaining - 4'd1;
          fall_n      = 5'd0;
        end
      end
      ACTIVE: begin
        prev_aaah_n = aaah;
        if (aaah) begin
          if (fall_cnt != SAT_L) begin
            fall_n = fall_cnt + 5'd1;
          end
        end else if (landed) begin
          fall_n = 5'd0;
        end
        // Splat wins over a save seen on the same cycle.
        if (hit_floor) begin
          splat_n    = 1'b1;
          lost_cnt_n = lost_cnt + 4'd1;
          retire     = 1'b1;
        end else if (at_home) begin
          saved_n     = 1'b1;
          saved_cnt_n = saved_cnt + 4'd1;
          retire      = 1'b1;
        end
        if (dig_edge && walking && !aaah) begin
          dig_n = 1'b1;
        end
        if (retire) begin
          prev_aaah_n = 1'b0;
          fall_n      = 5'd0;
          if (remaining == 4'd0) begin
            state_n = DONE;
          end else begin
            state_n = SPAWN;
            timer_n = GAP_L;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    lem_reset_n = (state_n != ACTIVE);
    done_n      = (state_n == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= 4'd0;
      fall_cnt  <= 5'd0;
      prev_aaah <= 1'b0;
      prev_dig  <= 1'b0;
      lem_reset <= 1'b1;
      dig       <= 1'b0;
      splat     <= 1'b0;
      saved     <= 1'b0;
      saved_cnt <= 4'd0;
      lost_cnt  <= 4'd0;
      remaining <= NUM_L;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      fall_cnt  <= fall_n;
      prev_aaah <= prev_aaah_n;
      prev_dig  <= dig_req;
      lem_reset <= lem_reset_n;
      dig       <= dig_n;
      splat     <= splat_n;
      saved     <= saved_n;
      saved_cnt <= saved_cnt_n;
      lost_cnt  <= lost_cnt_n;
      remaining <= remaining_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_lemming_level_ctrl.sv
// Randomized scoreboard bench for lemming_level_ctrl
// against a level-rules reference model.
module tb_lemming_level_ctrl;

  localparam int N   = 2;
  localparam int GAP = 4;
  localparam int LIM = 20;

  typedef struct packed {
    logic       lem_reset;
    logic       dig;
    logic       splat;
    logic       saved;
    logic [3:0] saved_cnt;
    logic [3:0] lost_cnt;
    logic [3:0] remaining;
    logic       done;
  } exp_t;

  logic clk;
  logic reset;
  logic start;
  logic walk_left;
  logic walk_right;
  logic aaah;
  logic at_exit;
  logic dig_req;
  logic lem_reset;
  logic dig;
  logic splat;
  logic saved;
  logic [3:0] saved_cnt;
  logic [3:0] lost_cnt;
  logic [3:0] remaining;
  logic done;

  lemming_level_ctrl #(
    .NUM_LEMMINGS(N),
    .SPAWN_GAP(GAP),
    .FALL_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .walk_left(walk_left),
    .walk_right(walk_right),
    .aaah(aaah),
    .at_exit(at_exit),
    .dig_req(dig_req),
    .lem_reset(lem_reset),
    .dig(dig),
    .splat(splat),
    .saved(saved),
    .saved_cnt(saved_cnt),
    .lost_cnt(lost_cnt),
    .remaining(remaining),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: phase 0 idle, 1 hatch,
  // 2 lemming out, 3 level done.
  int ph        = 0;
  int hatch     = 0;
  int air       = 0;
  int released  = 0;
  int n_saved   = 0;
  int n_lost    = 0;
  bit was_fall  = 0;
  bit dig_prev  = 0;

  task automatic model_step(
    input logic st, input logic wl,
    input logic wr, input logic aa,
    input logic ex, input logic dr,
    input logic rs, output exp_t e
  );
    bit walking;
    bit landed;
    bit retire;
    e = '0;
    if (rs) begin
      ph       = 0;
      air      = 0;
      was_fall = 0;
      released = 0;
      n_saved  = 0;
      n_lost   = 0;
      dig_prev = 0;
    end else begin
      walking = wl || wr;
      retire  = 0;
      case (ph)
        0, 3: begin
          if (st) begin
            ph       = 1;
            hatch    = GAP;
            released = 0;
            n_saved  = 0;
            n_lost   = 0;
          end
        end
        1: begin
          hatch--;
          if (hatch == 0) begin
            released++;
            ph       = 2;
            air      = 0;
            was_fall = 0;
          end
        end
        default: begin
          landed = was_fall && !aa;
          if (landed && air > LIM) begin
            n_lost++;
            e.splat = 1'b1;
            retire  = 1;
          end else if (ex && walking && !aa) begin
            n_saved++;
            e.saved = 1'b1;
            retire  = 1;
          end
          if (dr && !dig_prev && walking && !aa)
            e.dig = 1'b1;
          if (aa) air = (air < 31) ? air + 1 : 31;
          else if (landed) air = 0;
          was_fall = aa;
          if (retire) begin
            if (released == N) ph = 3;
            else begin
              ph    = 1;
              hatch = GAP;
            end
          end
        end
      endcase
      dig_prev = dr;
    end
    e.lem_reset = (ph != 2);
    e.done      = (ph == 3);
    e.saved_cnt = 4'(n_saved);
    e.lost_cnt  = 4'(n_lost);
    e.remaining = 4'(N - released);
  endtask

  // One clock of stimulus; expected result queued.
  task automatic cyc(
    input logic st, input logic wl,
    input logic wr, input logic aa,
    input logic ex, input logic dr,
    input logic rs, input int n
  );
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start      = st;
      walk_left  = wl;
      walk_right = wr;
      aaah       = aa;
      at_exit    = ex;
      dig_req    = dr;
      reset      = rs;
      model_step(st, wl, wr, aa, ex, dr, rs, e);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk(
    input string nm, input int act, input int req
  );
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, req, $time);
    end
  endtask

  // Monitor: compare DUT outputs after each edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("lem_reset", int'(lem_reset), int'(e.lem_reset));
        chk("dig", int'(dig), int'(e.dig));
        chk("splat", int'(splat), int'(e.splat));
        chk("saved", int'(saved), int'(e.saved));
        chk("saved_cnt", int'(saved_cnt), int'(e.saved_cnt));
        chk("lost_cnt", int'(lost_cnt), int'(e.lost_cnt));
        chk("remaining", int'(remaining), int'(e.remaining));
        chk("done", int'(done), int'(e.done));
      end
    end
  end

  initial begin : stim
    int   fall_left;
    logic r_aa;
    logic r_wl;
    logic r_wr;
    logic r_ex;
    logic r_dr;
    logic r_st;
    logic r_rs;
    start      = 1'b0;
    walk_left  = 1'b0;
    walk_right = 1'b0;
    aaah       = 1'b0;
    at_exit    = 1'b0;
    dig_req    = 1'b0;
    reset      = 1'b1;
    // reset, then reset together with start
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 2);
    // spawn first lemming
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 5);
    cyc(0, 0, 1, 0, 0, 0, 0, 3);
    // held dig request
    cyc(0, 0, 1, 0, 0, 1, 0, 6);
    cyc(0, 0, 1, 0, 0, 0, 0, 2);
    // survivable fall
    cyc(0, 0, 0, 1, 0, 0, 0, 20);
    cyc(0, 0, 1, 0, 0, 0, 0, 3);
    // dig request rising while falling
    cyc(0, 0, 0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1, 0, 2);
    cyc(0, 0, 1, 0, 0, 1, 0, 2);
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    // fatal fall landing on exit tile
    cyc(0, 0, 0, 1, 0, 0, 0, 21);
    cyc(0, 1, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 5);
    // second lemming saved, level done
    cyc(0, 1, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 3);
    // restart level
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 6);
    cyc(0, 1, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 5);
    // reset mid-fall
    cyc(0, 0, 0, 1, 0, 0, 0, 10);
    cyc(1, 0, 0, 1, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 2);
    // randomized play
    fall_left = 0;
    r_dr      = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r_aa = (fall_left > 0);
      if (fall_left > 0) fall_left--;
      else if ($urandom_range(0, 11) == 0)
        fall_left = $urandom_range(1, 25);
      r_wl = ($urandom_range(0, 2) != 0);
      r_wr = ($urandom_range(0, 3) == 0);
      r_ex = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) r_dr = ~r_dr;
      r_st = ($urandom_range(0, 19) == 0);
      r_rs = ($urandom_range(0, 399) == 0);
      cyc(r_st, r_wl, r_wr, r_aa, r_ex, r_dr, r_rs, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
